// File: rtl/demux_1to4_reg_pkg.sv
// Shared constants for the 1-to-4 registered demultiplexer.
package demux_1to4_reg_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready handshake and a wrapping
// delivery counter that steps on every output handshake.
module demux_slot #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  always_comb begin
    pop     = valid_q && out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, pop};
    // A load on the same edge as a pop refills the slot without a bubble.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: select decode, ready mux and bus packing
// around one demux_slot per channel.
module demux_1to4_reg
  import demux_1to4_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] out_cnt
);

  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] slot_valid;

  // Ready depends only on the addressed slot, never on in_valid.
  always_comb begin
    in_ready = !slot_valid[in_sel] || out_ready[in_sel];
  end

  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      load[i] = in_valid && in_ready && (in_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .load_data(in_data),
      .out_valid(slot_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g*WIDTH +: WIDTH]),
      .out_cnt  (out_cnt[g*CNT_W +: CNT_W])
    );
  end

  assign out_valid = slot_valid;

endmodule

// File: doc/demux_1to4_reg.md
DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width per channel.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of each per-channel delivery counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark in_data/in_sel as valid.
REQ-006 in_ready  output  1  SHALL indicate the block accepts the current input this cycle.
REQ-007 in_data  input  WIDTH  SHALL be the input payload.
REQ-008 in_sel  input  2  SHALL select the destination channel (0=a, 1=b, 2=c, 3=d).
REQ-009 out_valid  output  4  SHALL mark each channel's slot as holding data; bit i = channel i.
REQ-010 out_ready  input  4  SHALL be per-channel consumer ready; bit i = channel i.
REQ-011 out_data  output  4*WIDTH  SHALL carry the channel i slot in bits [i*WIDTH +: WIDTH].
REQ-012 out_cnt  output  4*CNT_W  SHALL carry the channel i delivery count in bits [i*CNT_W +: CNT_W].

Function
REQ-013 Input handshake SHALL occur when in_valid && in_ready at posedge clk.
REQ-014 in_ready SHALL equal !out_valid[in_sel] || out_ready[in_sel]; it is combinational and SHALL NOT depend on in_valid.
REQ-015 On an input handshake, the slot of channel in_sel SHALL load in_data and set out_valid[in_sel] on the same edge (one-cycle latency, no combinational path from in_data to out_data).
REQ-016 Output handshake on channel i SHALL occur when out_valid[i] && out_ready[i] at posedge clk; out_valid[i] SHALL then clear unless REQ-017 applies.
REQ-017 Simultaneous output handshake and input handshake on the same channel SHALL keep out_valid[i]=1 and load the new data (no bubble, no loss).
REQ-018 While out_valid[i]=1 and out_ready[i]=0, out_data channel i SHALL stay constant.
REQ-019 Channels SHALL be independent: a stalled channel SHALL block only inputs addressed to it.
REQ-020 out_data for a channel with out_valid=0 SHALL retain its last value (don't-care to consumers).
REQ-021 Counter i SHALL increment by 1 on each output handshake on channel i, wrapping from 2^CNT_W-1 to 0.
REQ-022 in_sel and in_data changes while in_valid=1 and in_ready=0 SHALL be permitted; the value present at the handshake edge is the one taken.

Reset
REQ-023 While rst_n=0: out_valid=4'b0000, out_data=0, out_cnt=0, regardless of clk.
REQ-024 in_ready SHALL evaluate to 1 during and immediately after reset (all slots empty).
REQ-025 Reset asserted mid-operation SHALL discard all held data; no output handshake is counted on the reset edge.
REQ-026 Reset deassertion SHALL be used synchronised externally; the block SHALL accept its first input on the first posedge after rst_n rises.

Structure
REQ-027 Constants NUM_CH=4 and SEL_W=2 SHALL live in the shared project defines file, not in this module.
REQ-028 The one-entry holding register plus its counter SHALL be a sub-module demux_slot, instantiated NUM_CH times with generate.
REQ-029 Top level SHALL contain only the sel decode, in_ready mux, and bus packing.

Verification
REQ-030 Reset: rst_n=0 for 3 cycles -> out_valid=0000, out_cnt all 0, in_ready=1.
REQ-031 Sweep: out_ready=1111, send 0x4,0x1,0x9,0x3 with sel 0..3 on consecutive cycles -> each out_valid bit pulses one cycle after its input, data matches, each out_cnt=1.
REQ-032 Stall: out_ready[2]=0, send 0xD to sel=2 then 0x5 to sel=2 -> in_ready=0 on second, channel 2 holds 0xD; raise out_ready[2] -> 0xD drains, 0x5 accepted same edge, out_valid[2] stays 1.
REQ-033 Isolation: channel 1 stalled full, send 0x7 to sel=3 -> accepted, out_data ch3=0x7 next cycle, channel 1 unchanged.
REQ-034 Wrap: 256 handshakes on channel 0 with CNT_W=8 -> out_cnt ch0 returns to 0.
REQ-035 Mid-op reset: all four slots full, pulse rst_n low between edges -> out_valid clears immediately, counters 0, no extra count on next edge.
